// File: rtl/cq_pkg.sv
// Shared types and helpers for the multi-channel quality-control block.
// Optional verdict timeout is enabled with the CQ_TIMEOUT_EN macro.
package cq_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        INSPECT = 1'b1
    } cq_estado_t;

    localparam int unsigned MAX_CH = 16;

    // Callers zero-extend their N_CH-wide vector to MAX_CH bits.
    function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] maxv);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, maxv}) ? maxv : s[31:0];
    endfunction

endpackage

// File: rtl/cq_multicanal_canal.sv
// One inspection channel: two-state Mealy FSM, its outputs and the optional
// verdict timeout counter (present only when CQ_TIMEOUT_EN is defined).
module cq_canal
    import cq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic pronto_i,
    input  logic aprovado_i,
    input  logic reprovado_i,
    output logic conta_o,
    output logic descarte_o,
    output logic posicao_o,
    output logic timeout_o
);

    cq_estado_t estado_q, estado_d;
    logic       verdict;
    logic       expire;
    logic       inspect;

    assign inspect = (estado_q == INSPECT);
    assign verdict = aprovado_i | reprovado_i;

`ifdef CQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          timeout_q;

    assign expire    = inspect & ~verdict & (tmr_q == TW'(TIMEOUT - 1));
    assign timeout_o = timeout_q;

    // Cleared while idle and on every verdict, so each new piece starts at 0.
    always_comb begin
        tmr_d = tmr_q;
        if (!inspect || verdict) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= expire;
        end
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE: begin
                if (pronto_i) estado_d = INSPECT;
            end
            INSPECT: begin
                if (verdict) begin
                    estado_d = pronto_i ? INSPECT : IDLE;
                end else if (expire) begin
                    estado_d = IDLE;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_comb begin
        posicao_o  = 1'b0;
        conta_o    = 1'b0;
        descarte_o = 1'b0;
        if (RST_n) begin
            posicao_o  = inspect | pronto_i;
            conta_o    = inspect & aprovado_i & ~reprovado_i;
            descarte_o = (inspect & reprovado_i) | expire;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            estado_q <= IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

endmodule

// File: rtl/cq_multicanal.sv
// Multi-channel quality-control top: N_CH channel FSMs plus shared saturating
// totals and batch detection. Verdict timeout is enabled with CQ_TIMEOUT_EN.
module cq_multicanal
    import cq_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8,
    parameter int BATCH   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [N_CH-1:0]  Pronto,
    input  logic [N_CH-1:0]  Aprovado,
    input  logic [N_CH-1:0]  Reprovado,
    output logic [N_CH-1:0]  Conta,
    output logic [N_CH-1:0]  Descarte,
    output logic [N_CH-1:0]  Posicao,
    output logic [N_CH-1:0]  Timeout,
    output logic [CNT_W-1:0] Total_Aprovados,
    output logic [CNT_W-1:0] Total_Reprovados,
    output logic             Lote_Completo
);

    // BATCH >= N_CH guarantees at most one batch completes per cycle.
    if (N_CH < 1 || N_CH > 16 || CNT_W < 1 || CNT_W > 31 || BATCH < 2 ||
        BATCH < N_CH || BATCH > (1 << CNT_W) - 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cq_multicanal: invalid parameter combination");
    end

    localparam logic [31:0] MAX_TOT = 32'((64'd1 << CNT_W) - 64'd1);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_canal
        cq_canal #(
            .TIMEOUT (TIMEOUT)
        ) u_canal (
            .CLK         (CLK),
            .RST_n       (RST_n),
            .pronto_i    (Pronto[gi]),
            .aprovado_i  (Aprovado[gi]),
            .reprovado_i (Reprovado[gi]),
            .conta_o     (Conta[gi]),
            .descarte_o  (Descarte[gi]),
            .posicao_o   (Posicao[gi]),
            .timeout_o   (Timeout[gi])
        );
    end

    logic [CNT_W-1:0] tot_a_q, tot_a_d;
    logic [CNT_W-1:0] tot_r_q, tot_r_d;
    logic [CNT_W-1:0] lote_cnt_q, lote_cnt_d;
    logic             lote_q, lote_d;
    logic [4:0]       inc_a, inc_r;
    logic [31:0]      lote_sum;

    always_comb begin
        inc_a      = popcount(MAX_CH'(Conta));
        inc_r      = popcount(MAX_CH'(Descarte));
        tot_a_d    = CNT_W'(sat_add(32'(tot_a_q), 32'(inc_a), MAX_TOT));
        tot_r_d    = CNT_W'(sat_add(32'(tot_r_q), 32'(inc_r), MAX_TOT));
        lote_sum   = 32'(lote_cnt_q) + 32'(inc_a);
        lote_cnt_d = CNT_W'(lote_sum);
        lote_d     = 1'b0;
        if (lote_sum >= 32'(BATCH)) begin
            lote_cnt_d = CNT_W'(lote_sum - 32'(BATCH));
            lote_d     = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            tot_a_q    <= '0;
            tot_r_q    <= '0;
            lote_cnt_q <= '0;
            lote_q     <= 1'b0;
        end else begin
            tot_a_q    <= tot_a_d;
            tot_r_q    <= tot_r_d;
            lote_cnt_q <= lote_cnt_d;
            lote_q     <= lote_d;
        end
    end

    assign Total_Aprovados  = tot_a_q;
    assign Total_Reprovados = tot_r_q;
    assign Lote_Completo    = lote_q;

endmodule

// File: tb/tb_cq_multicanal.sv
// Self-checking bench for cq_multicanal: directed scenarios plus a randomized
// run, all compared every cycle against a piece-level behavioural model.
module tb_cq_multicanal;

    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int B    = 10;
    localparam int TO   = 15;
    localparam int MAXT = (1 << CW) - 1;
`ifdef CQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic [N-1:0]  Pronto = '0, Aprovado = '0, Reprovado = '0;
    logic [N-1:0]  Conta, Descarte, Posicao, Timeout;
    logic [CW-1:0] Total_Aprovados, Total_Reprovados;
    logic          Lote_Completo;

    cq_multicanal #(.N_CH(N), .CNT_W(CW), .BATCH(B), .TIMEOUT(TO)) dut (
        .CLK              (CLK),
        .RST_n            (RST_n),
        .Pronto           (Pronto),
        .Aprovado         (Aprovado),
        .Reprovado        (Reprovado),
        .Conta            (Conta),
        .Descarte         (Descarte),
        .Posicao          (Posicao),
        .Timeout          (Timeout),
        .Total_Aprovados  (Total_Aprovados),
        .Total_Reprovados (Total_Reprovados),
        .Lote_Completo    (Lote_Completo)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Model: which channels hold a piece, how long each piece has waited.
    bit           busy [N];
    int           waited [N];
    int           m_ta, m_tr, m_lote;
    bit           m_lc;
    logic [N-1:0] m_to;
    bit           m_valid = 1'b0;
    logic [N-1:0] e_pos, e_conta, e_desc, e_exp;
    logic [N-1:0] cap_pos, cap_conta, cap_desc;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void model_comb();
        for (int c = 0; c < N; c++) begin
            e_pos[c] = 1'b0; e_conta[c] = 1'b0; e_desc[c] = 1'b0; e_exp[c] = 1'b0;
            if (RST_n) begin
                e_exp[c]   = TO_EN && busy[c] && !(Aprovado[c] || Reprovado[c]) &&
                             (waited[c] == TO - 1);
                e_pos[c]   = busy[c] || Pronto[c];
                e_conta[c] = busy[c] && Aprovado[c] && !Reprovado[c];
                e_desc[c]  = (busy[c] && Reprovado[c]) || e_exp[c];
            end
        end
    endfunction

    function automatic void model_edge();
        m_valid = 1'b1;
        if (!RST_n) begin
            for (int c = 0; c < N; c++) begin busy[c] = 1'b0; waited[c] = 0; end
            m_ta = 0; m_tr = 0; m_lote = 0; m_lc = 1'b0; m_to = '0;
            return;
        end
        m_to   = e_exp;
        m_ta   = (m_ta + $countones(e_conta) > MAXT) ? MAXT : m_ta + $countones(e_conta);
        m_tr   = (m_tr + $countones(e_desc) > MAXT) ? MAXT : m_tr + $countones(e_desc);
        m_lote = m_lote + $countones(e_conta);
        m_lc   = (m_lote >= B);
        if (m_lc) m_lote = m_lote - B;
        for (int c = 0; c < N; c++) begin
            if (!busy[c] || Aprovado[c] || Reprovado[c]) begin
                busy[c]   = Pronto[c];
                waited[c] = 0;
            end else if (e_exp[c]) begin
                busy[c] = 1'b0;
            end else begin
                waited[c]++;
            end
        end
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply(input bit rst, input logic [N-1:0] p, input logic [N-1:0] a,
                         input logic [N-1:0] r);
        RST_n = rst; Pronto = p; Aprovado = a; Reprovado = r;
        #1;
        model_comb();
        chk("Posicao", int'(Posicao), int'(e_pos));
        chk("Conta", int'(Conta), int'(e_conta));
        chk("Descarte", int'(Descarte), int'(e_desc));
        if (m_valid) begin
            chk("Timeout", int'(Timeout), int'(m_to));
            chk("Total_Aprovados", int'(Total_Aprovados), m_ta);
            chk("Total_Reprovados", int'(Total_Reprovados), m_tr);
            chk("Lote_Completo", int'(Lote_Completo), int'(m_lc));
            chk("lote_cnt", int'(dut.lote_cnt_q), m_lote);
        end
        cap_pos = Posicao; cap_conta = Conta; cap_desc = Descarte;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        apply(1'b0, '0, '0, '0);
        apply(1'b0, '0, '0, '0);
    endtask

    initial begin
        int first_k;
        int tseen;
        logic [N-1:0] a, r, any_desc, any_to;
        int dens;

        @(negedge CLK);
        do_reset();
        chk("reset_totA", int'(Total_Aprovados), 0);
        chk("reset_totR", int'(Total_Reprovados), 0);
        chk("reset_lote", int'(Lote_Completo), 0);

        // Single piece on ch0, verdict three cycles after arrival.
        apply(1'b1, 4'b0001, '0, '0);
        apply(1'b1, '0, '0, '0);
        apply(1'b1, '0, '0, '0);
        apply(1'b1, '0, 4'b0001, '0);
        chk("single_conta", int'(cap_conta), 1);
        chk("single_pos0", int'(cap_pos[0]), 1);
        chk("single_totA", int'(Total_Aprovados), 1);

        // Simultaneous approve/reject on ch1.
        do_reset();
        apply(1'b1, 4'b0010, '0, '0);
        apply(1'b1, '0, 4'b0010, 4'b0010);
        chk("both_desc", int'(cap_desc), 2);
        chk("both_conta", int'(cap_conta), 0);
        chk("both_totR", int'(Total_Reprovados), 1);

        // Back-to-back on ch2.
        do_reset();
        apply(1'b1, 4'b0100, '0, '0);
        apply(1'b1, 4'b0100, 4'b0100, '0);
        chk("b2b_conta", int'(cap_conta), 4);
        apply(1'b1, '0, '0, '0);
        chk("b2b_pos2", int'(cap_pos[2]), 1);
        apply(1'b1, '0, '0, 4'b0100);
        chk("b2b_desc", int'(cap_desc), 4);
        chk("b2b_totA", int'(Total_Aprovados), 1);
        chk("b2b_totR", int'(Total_Reprovados), 1);

        // Batch: 4 approvals per cycle for 3 cycles.
        do_reset();
        apply(1'b1, 4'b1111, '0, '0);
        apply(1'b1, 4'b1111, 4'b1111, '0);
        chk("batch_lc1", int'(Lote_Completo), 0);
        apply(1'b1, 4'b1111, 4'b1111, '0);
        chk("batch_lc2", int'(Lote_Completo), 0);
        apply(1'b1, '0, 4'b1111, '0);
        chk("batch_lc3", int'(Lote_Completo), 1);
        chk("batch_cnt", int'(dut.lote_cnt_q), 2);
        chk("batch_totA", int'(Total_Aprovados), 12);
        apply(1'b1, '0, '0, '0);
        chk("batch_lc_once", int'(Lote_Completo), 0);

        // Saturation: 4 rejects per cycle for 70 cycles.
        do_reset();
        apply(1'b1, 4'b1111, '0, '0);
        for (int k = 0; k < 70; k++) apply(1'b1, 4'b1111, '0, 4'b1111);
        chk("sat_totR", int'(Total_Reprovados), MAXT);

        // Pronto with no verdict on ch3, bounded wait for a forced discard.
        do_reset();
        apply(1'b1, 4'b1000, '0, '0);
        first_k = 0; tseen = 0;
        for (int k = 1; k <= 20; k++) begin
            apply(1'b1, '0, '0, '0);
            if (cap_desc[3] && first_k == 0) begin
                first_k = k;
                tseen = int'(Timeout[3]);
            end
        end
`ifdef CQ_TIMEOUT_EN
        chk("timeout_cycle", first_k, TO);
        chk("timeout_pulse", tseen, 1);
`else
        chk("no_timeout_desc", first_k, 0);
        chk("no_timeout_pos", int'(Posicao[3]), 1);
`endif

        // Reset mid-wait drops the piece silently.
        do_reset();
        apply(1'b1, 4'b1000, '0, '0);
        for (int k = 0; k < 5; k++) apply(1'b1, '0, '0, '0);
        apply(1'b0, '0, '0, '0);
        chk("rst_mid_desc", int'(cap_desc), 0);
        any_desc = '0; any_to = '0;
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, '0, '0, '0);
            any_desc |= cap_desc;
            any_to   |= Timeout;
        end
        chk("rst_mid_nodesc", int'(any_desc), 0);
        chk("rst_mid_noto", int'(any_to), 0);
        chk("rst_mid_totR", int'(Total_Reprovados), 0);

        // Randomized run, alternating dense and sparse verdict phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            dens = ((i / 400) % 2 == 0) ? 2 : 40;
            for (int c = 0; c < N; c++) begin
                a[c] = ($urandom_range(0, dens) == 0);
                r[c] = ($urandom_range(0, dens) == 0);
            end
            apply($urandom_range(0, 499) != 0, N'($urandom), a, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
